// File: rtl/pipe_stage_chain_if.sv
// Issue/stage bus of pipe_stage_chain: master = issue and control side, slave = the chain.
interface pipe_stage_chain_if #(
  parameter int unsigned STAGES = 4,
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned SEL_W  = 4
);
  logic                     STALL;
  logic                     FLUSH;
  logic [SEL_W-1:0]         FLUSH_DEPTH;
  logic                     IN_VALID;
  logic [WIDTH-1:0]         IN_DATA;
  logic [ADDR_W-1:0]        IN_RD;
  logic                     IN_WE;
  logic                     IN_IS_LOAD;
  logic [ADDR_W-1:0]        IN_RS1;
  logic [ADDR_W-1:0]        IN_RS2;
  logic                     IN_READY;
  logic [STAGES-1:0]        STAGE_VALID;
  logic [STAGES*WIDTH-1:0]  STAGE_DATA;
  logic                     OUT_VALID;
  logic [WIDTH-1:0]         OUT_DATA;
  logic [SEL_W-1:0]         FWD1_SEL;
  logic [SEL_W-1:0]         FWD2_SEL;
  logic                     LOAD_USE;
  logic [31:0]              STALL_CNT;
  logic [31:0]              BUBBLE_CNT;
  logic [31:0]              FLUSH_CNT;

  modport master (
    output STALL, FLUSH, FLUSH_DEPTH, IN_VALID, IN_DATA, IN_RD, IN_WE, IN_IS_LOAD, IN_RS1, IN_RS2,
    input  IN_READY, STAGE_VALID, STAGE_DATA, OUT_VALID, OUT_DATA, FWD1_SEL, FWD2_SEL, LOAD_USE,
           STALL_CNT, BUBBLE_CNT, FLUSH_CNT
  );

  modport slave (
    input  STALL, FLUSH, FLUSH_DEPTH, IN_VALID, IN_DATA, IN_RD, IN_WE, IN_IS_LOAD, IN_RS1, IN_RS2,
    output IN_READY, STAGE_VALID, STAGE_DATA, OUT_VALID, OUT_DATA, FWD1_SEL, FWD2_SEL, LOAD_USE,
           STALL_CNT, BUBBLE_CNT, FLUSH_CNT
  );
endinterface

// File: rtl/pipe_stage_chain.sv
// Generic pipeline-register chain with stall, depth-selectable flush, load-use bubble and forwarding lookup.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_stage_chain #(
  parameter int unsigned STAGES = 4,
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned SEL_W  = 4
) (
  input logic               CLK,
  input logic               RESET,
  pipe_stage_chain_if.slave bus
);
  localparam logic [SEL_W-1:0] STAGES_SEL = SEL_W'(STAGES);

  logic [STAGES-1:0] valid_q, we_q, load_q;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [ADDR_W-1:0] rd_q   [STAGES];
  logic [STAGES-1:0] valid_n, we_n, load_n;
  logic [WIDTH-1:0]  data_n [STAGES];
  logic [ADDR_W-1:0] rd_n   [STAGES];

  logic                    advance_c, kill_c, hazard_c, load_use_c;
  logic [SEL_W-1:0]        depth_c, fwd1_c, fwd2_c;
  logic [STAGES*WIDTH-1:0] stage_data_c;

  // Edge control; a flush that kills at least one stage overrides the load-use bubble
  always_comb begin
    advance_c  = RESET & ~bus.STALL;
    depth_c    = (bus.FLUSH_DEPTH > STAGES_SEL) ? STAGES_SEL : bus.FLUSH_DEPTH;
    kill_c     = bus.FLUSH & (depth_c != '0);
    hazard_c   = valid_q[0] & load_q[0] & we_q[0] & (rd_q[0] != '0) & bus.IN_VALID &
                 ((bus.IN_RS1 == rd_q[0]) | (bus.IN_RS2 == rd_q[0]));
    load_use_c = advance_c & hazard_c & ~kill_c;
  end

  // Forwarding lookup: scan oldest to youngest so the youngest match wins
  always_comb begin
    fwd1_c = '0;
    fwd2_c = '0;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      if (valid_q[k] && we_q[k] && (rd_q[k] != '0)) begin
        if (rd_q[k] == bus.IN_RS1) fwd1_c = SEL_W'(k + 1);
        if (rd_q[k] == bus.IN_RS2) fwd2_c = SEL_W'(k + 1);
      end
    end
  end

  // Next-state: shift, insert input or bubble at stage 0, then kill the youngest stages
  always_comb begin
    valid_n = valid_q;
    we_n    = we_q;
    load_n  = load_q;
    data_n  = data_q;
    rd_n    = rd_q;
    if (!bus.STALL) begin
      for (int k = 1; k < int'(STAGES); k++) begin
        valid_n[k] = valid_q[k-1];
        we_n[k]    = we_q[k-1];
        load_n[k]  = load_q[k-1];
        data_n[k]  = data_q[k-1];
        rd_n[k]    = rd_q[k-1];
      end
      if (load_use_c) begin
        valid_n[0] = 1'b0;
        we_n[0]    = 1'b0;
        load_n[0]  = 1'b0;
        data_n[0]  = '0;
        rd_n[0]    = '0;
      end else begin
        valid_n[0] = bus.IN_VALID;
        we_n[0]    = bus.IN_WE;
        load_n[0]  = bus.IN_IS_LOAD;
        data_n[0]  = bus.IN_DATA;
        rd_n[0]    = bus.IN_RD;
      end
      if (kill_c) begin
        for (int k = 0; k < int'(STAGES); k++) begin
          if (SEL_W'(k) < depth_c) begin
            valid_n[k] = 1'b0;
            we_n[k]    = 1'b0;
            load_n[k]  = 1'b0;
            data_n[k]  = '0;
            rd_n[k]    = '0;
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid_q <= '0;
      we_q    <= '0;
      load_q  <= '0;
      for (int k = 0; k < int'(STAGES); k++) begin
        data_q[k] <= '0;
        rd_q[k]   <= '0;
      end
    end else begin
      valid_q <= valid_n;
      we_q    <= we_n;
      load_q  <= load_n;
      data_q  <= data_n;
      rd_q    <= rd_n;
    end
  end

  always_comb begin
    stage_data_c = '0;
    for (int k = 0; k < int'(STAGES); k++) stage_data_c[k*WIDTH +: WIDTH] = data_q[k];
  end

  assign bus.IN_READY    = advance_c & ~load_use_c;
  assign bus.LOAD_USE    = load_use_c;
  assign bus.FWD1_SEL    = fwd1_c;
  assign bus.FWD2_SEL    = fwd2_c;
  assign bus.STAGE_VALID = valid_q;
  assign bus.STAGE_DATA  = stage_data_c;
  assign bus.OUT_VALID   = valid_q[STAGES-1];
  assign bus.OUT_DATA    = data_q[STAGES-1];

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_q, bubble_cnt_q, flush_cnt_q;

  // Saturating event counters
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      if (bus.STALL && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (load_use_c && (bubble_cnt_q != '1)) bubble_cnt_q <= bubble_cnt_q + 32'd1;
      if (!bus.STALL && bus.FLUSH && (bus.FLUSH_DEPTH != '0) && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign bus.STALL_CNT  = stall_cnt_q;
  assign bus.BUBBLE_CNT = bubble_cnt_q;
  assign bus.FLUSH_CNT  = flush_cnt_q;
`else
  assign bus.STALL_CNT  = '0;
  assign bus.BUBBLE_CNT = '0;
  assign bus.FLUSH_CNT  = '0;
`endif
endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain: directed vector table, async-reset sequence, random run vs queue model.
module tb_pipe_stage_chain;
  localparam int unsigned STAGES = 4;
  localparam int unsigned WIDTH  = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned SEL_W  = 4;

  typedef struct { bit v; bit we; bit ld; int rd; logic [31:0] d; } ent_t;
  typedef struct { int st, fl, dp, iv, d, rd, we, ld, rs1, rs2, rdy, lu, f1, f2, sv, od; } vec_t;

  logic CLK;
  logic RESET;

  pipe_stage_chain_if #(.STAGES(STAGES), .WIDTH(WIDTH), .ADDR_W(ADDR_W), .SEL_W(SEL_W)) bus ();

  pipe_stage_chain #(.STAGES(STAGES), .WIDTH(WIDTH), .ADDR_W(ADDR_W), .SEL_W(SEL_W)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int checks = 0;
  int errors = 0;
  int st, fl, dp, iv, rd, we, ld, rs1, rs2;
  logic [31:0] din;
  ent_t mq[$];
  logic [31:0] m_stall, m_bubble, m_flush;
  vec_t vt [22];

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic ent_t zero_ent();
    ent_t e;
    e.v = 1'b0; e.we = 1'b0; e.ld = 1'b0; e.rd = 0; e.d = '0;
    return e;
  endfunction

  task automatic model_reset();
    mq.delete();
    for (int k = 0; k < int'(STAGES); k++) mq.push_back(zero_ent());
    m_stall = '0; m_bubble = '0; m_flush = '0;
  endtask

  // Reference model: the chain is a queue, youngest at the front
  function automatic int m_fwd(input int rs);
    for (int k = 0; k < int'(STAGES); k++)
      if (mq[k].v && mq[k].we && mq[k].rd != 0 && mq[k].rd == rs) return k + 1;
    return 0;
  endfunction

  function automatic int m_dsat();
    return (dp > int'(STAGES)) ? int'(STAGES) : dp;
  endfunction

  function automatic bit m_lu();
    bit kill;
    kill = (fl != 0) && (m_dsat() > 0);
    return (st == 0) && !kill && (iv != 0) && mq[0].v && mq[0].ld && mq[0].we && (mq[0].rd != 0) &&
           (rs1 == mq[0].rd || rs2 == mq[0].rd);
  endfunction

  task automatic model_edge();
    ent_t e;
    if (st != 0) begin
      if (m_stall != '1) m_stall = m_stall + 32'd1;
      return;
    end
    if (m_lu()) begin
      e = zero_ent();
      if (m_bubble != '1) m_bubble = m_bubble + 32'd1;
    end else begin
      e.v = (iv != 0); e.we = (we != 0); e.ld = (ld != 0); e.rd = rd; e.d = din;
    end
    if (fl != 0 && dp != 0 && m_flush != '1) m_flush = m_flush + 32'd1;
    mq.push_front(e);
    void'(mq.pop_back());
    if (fl != 0)
      for (int k = 0; k < m_dsat(); k++) mq[k] = zero_ent();
  endtask

  task automatic drive();
    bus.STALL       = 1'(st);
    bus.FLUSH       = 1'(fl);
    bus.FLUSH_DEPTH = SEL_W'(dp);
    bus.IN_VALID    = 1'(iv);
    bus.IN_DATA     = din;
    bus.IN_RD       = ADDR_W'(rd);
    bus.IN_WE       = 1'(we);
    bus.IN_IS_LOAD  = 1'(ld);
    bus.IN_RS1      = ADDR_W'(rs1);
    bus.IN_RS2      = ADDR_W'(rs2);
  endtask

  task automatic check_state(input string tag);
    logic [STAGES-1:0]       sv;
    logic [STAGES*WIDTH-1:0] sd;
    sv = '0;
    sd = '0;
    for (int k = 0; k < int'(STAGES); k++) begin
      sv[k] = mq[k].v;
      sd[k*WIDTH +: WIDTH] = mq[k].d;
    end
    chk({tag, ".stage_valid"}, 128'(bus.STAGE_VALID), 128'(sv));
    chk({tag, ".stage_data"},  128'(bus.STAGE_DATA),  128'(sd));
    chk({tag, ".out_valid"},   128'(bus.OUT_VALID),   128'(mq[STAGES-1].v));
    chk({tag, ".out_data"},    128'(bus.OUT_DATA),    128'(mq[STAGES-1].d));
`ifdef PIPE_PERF_CNT_EN
    chk({tag, ".stall_cnt"},  128'(bus.STALL_CNT),  128'(m_stall));
    chk({tag, ".bubble_cnt"}, 128'(bus.BUBBLE_CNT), 128'(m_bubble));
    chk({tag, ".flush_cnt"},  128'(bus.FLUSH_CNT),  128'(m_flush));
`else
    chk({tag, ".stall_cnt"},  128'(bus.STALL_CNT),  128'(0));
    chk({tag, ".bubble_cnt"}, 128'(bus.BUBBLE_CNT), 128'(0));
    chk({tag, ".flush_cnt"},  128'(bus.FLUSH_CNT),  128'(0));
`endif
  endtask

  // One clock: entered and left at posedge+1
  task automatic cycle(input bit use_vec, input vec_t v, input string tag);
    bit e_lu, e_rdy;
    drive();
    #1;
    e_lu  = m_lu();
    e_rdy = (st == 0) && !e_lu;
    chk({tag, ".in_ready"}, 128'(bus.IN_READY), 128'(e_rdy));
    chk({tag, ".load_use"}, 128'(bus.LOAD_USE), 128'(e_lu));
    chk({tag, ".fwd1_sel"}, 128'(bus.FWD1_SEL), 128'(m_fwd(rs1)));
    chk({tag, ".fwd2_sel"}, 128'(bus.FWD2_SEL), 128'(m_fwd(rs2)));
    if (use_vec) begin
      chk({tag, ".tbl_in_ready"}, 128'(bus.IN_READY), 128'(v.rdy));
      chk({tag, ".tbl_load_use"}, 128'(bus.LOAD_USE), 128'(v.lu));
      chk({tag, ".tbl_fwd1"},     128'(bus.FWD1_SEL), 128'(v.f1));
      chk({tag, ".tbl_fwd2"},     128'(bus.FWD2_SEL), 128'(v.f2));
    end
    @(posedge CLK);
    model_edge();
    #1;
    check_state(tag);
    if (use_vec) begin
      chk({tag, ".tbl_stage_valid"}, 128'(bus.STAGE_VALID), 128'(v.sv));
      chk({tag, ".tbl_out_data"},    128'(bus.OUT_DATA),    128'(v.od));
    end
  endtask

  initial begin
    vec_t nv;
    // st fl dp iv  d rd we ld rs1 rs2 | rdy lu f1 f2 | stage_valid out_data
    vt[0]  = '{0, 0, 0, 1,  1, 1, 1, 0, 0, 0,  1, 0, 0, 0,  1,  0};
    vt[1]  = '{0, 0, 0, 1,  2, 2, 1, 0, 1, 0,  1, 0, 1, 0,  3,  0};
    vt[2]  = '{0, 0, 0, 1,  3, 3, 1, 0, 2, 1,  1, 0, 1, 2,  7,  0};
    vt[3]  = '{0, 0, 0, 1,  4, 4, 1, 0, 0, 0,  1, 0, 0, 0, 15,  1};
    vt[4]  = '{0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 14,  2};
    vt[5]  = '{0, 0, 0, 1,  5, 5, 1, 1, 0, 0,  1, 0, 0, 0, 13,  3};
    vt[6]  = '{0, 0, 0, 1,  6, 6, 1, 0, 5, 0,  0, 1, 1, 0, 10,  4};
    vt[7]  = '{0, 0, 0, 1,  6, 6, 1, 0, 5, 0,  1, 0, 2, 0,  5,  0};
    vt[8]  = '{1, 1, 2, 1,  7, 7, 1, 0, 6, 5,  0, 0, 1, 3,  5,  0};
    vt[9]  = '{1, 1, 2, 1,  7, 7, 1, 0, 6, 5,  0, 0, 1, 3,  5,  0};
    vt[10] = '{1, 1, 2, 1,  7, 7, 1, 0, 6, 5,  0, 0, 1, 3,  5,  0};
    vt[11] = '{0, 1, 2, 1,  7, 7, 1, 0, 6, 5,  1, 0, 1, 3,  8,  5};
    vt[12] = '{0, 0, 0, 1,  8, 7, 1, 0, 0, 0,  1, 0, 0, 0,  1,  0};
    vt[13] = '{0, 0, 0, 1,  9, 9, 1, 0, 0, 0,  1, 0, 0, 0,  3,  0};
    vt[14] = '{0, 0, 0, 1, 10, 7, 1, 0, 0, 0,  1, 0, 0, 0,  7,  0};
    vt[15] = '{0, 0, 0, 1, 11, 0, 1, 0, 0, 0,  1, 0, 0, 0, 15,  8};
    vt[16] = '{1, 0, 0, 0,  0, 0, 0, 0, 0, 7,  0, 0, 0, 2, 15,  8};
    vt[17] = '{1, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 15,  8};
    vt[18] = '{0, 0, 0, 1, 12, 3, 1, 1, 0, 0,  1, 0, 0, 0, 15,  9};
    vt[19] = '{0, 1, 1, 1, 13, 4, 1, 0, 3, 0,  1, 0, 1, 0, 14, 10};
    vt[20] = '{0, 1, 9, 1, 14, 5, 1, 0, 0, 0,  1, 0, 0, 0,  0,  0};
    vt[21] = '{0, 1, 0, 1, 15, 1, 1, 0, 0, 0,  1, 0, 0, 0,  1,  0};
    nv = vt[0];

    st = 0; fl = 0; dp = 0; iv = 0; rd = 0; we = 0; ld = 0; rs1 = 0; rs2 = 0; din = '0;
    drive();
    RESET = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_state("reset");
    chk("reset.in_ready", 128'(bus.IN_READY), 128'(0));
    RESET = 1'b1;

    for (int i = 0; i < 22; i++) begin
      st = vt[i].st; fl = vt[i].fl; dp = vt[i].dp; iv = vt[i].iv; din = 32'(vt[i].d);
      rd = vt[i].rd; we = vt[i].we; ld = vt[i].ld; rs1 = vt[i].rs1; rs2 = vt[i].rs2;
      cycle(1'b1, vt[i], $sformatf("vec%0d", i));
`ifdef PIPE_PERF_CNT_EN
      if (i == 11) begin
        chk("vec11.tbl_stall_cnt", 128'(bus.STALL_CNT), 128'(3));
        chk("vec11.tbl_flush_cnt", 128'(bus.FLUSH_CNT), 128'(1));
      end
`endif
    end
`ifdef PIPE_PERF_CNT_EN
    chk("table.stall_cnt",  128'(bus.STALL_CNT),  128'(5));
    chk("table.bubble_cnt", 128'(bus.BUBBLE_CNT), 128'(1));
    chk("table.flush_cnt",  128'(bus.FLUSH_CNT),  128'(3));
`else
    chk("table.flush_cnt",  128'(bus.FLUSH_CNT),  128'(0));
`endif

    // Fill the chain, then pull reset low between edges and hold it across an edge
    st = 0; fl = 0; dp = 0; iv = 1; we = 1; ld = 0; rs1 = 0; rs2 = 0;
    for (int i = 0; i < 4; i++) begin
      din = 32'hA0 + 32'(i);
      rd = i + 1;
      cycle(1'b0, nv, "fill");
    end
    chk("fill.stage_valid", 128'(bus.STAGE_VALID), 128'(15));
    din = 32'hBEEF;
    drive();
    #2;
    RESET = 1'b0;
    #1;
    chk("async_rst.stage_valid", 128'(bus.STAGE_VALID), 128'(0));
    chk("async_rst.out_data",    128'(bus.OUT_DATA),    128'(0));
    chk("async_rst.out_valid",   128'(bus.OUT_VALID),   128'(0));
    chk("async_rst.stage_data",  128'(bus.STAGE_DATA),  128'(0));
    chk("async_rst.in_ready",    128'(bus.IN_READY),    128'(0));
    @(posedge CLK);
    #1;
    chk("rst_held.stage_valid", 128'(bus.STAGE_VALID), 128'(0));
    chk("rst_held.out_data",    128'(bus.OUT_DATA),    128'(0));
    model_reset();
    check_state("rst_held");
    RESET = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      st  = ($urandom_range(0, 9) < 2) ? 1 : 0;
      fl  = ($urandom_range(0, 9) < 2) ? 1 : 0;
      dp  = int'($urandom_range(0, 9));
      iv  = ($urandom_range(0, 3) != 0) ? 1 : 0;
      din = $urandom;
      rd  = int'($urandom_range(0, 7));
      we  = ($urandom_range(0, 3) != 0) ? 1 : 0;
      ld  = ($urandom_range(0, 2) == 0) ? 1 : 0;
      rs1 = int'($urandom_range(0, 7));
      rs2 = int'($urandom_range(0, 7));
      cycle(1'b0, nv, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised pipeline-register backbone for the RV32IM core. It replaces the hand-written per-stage register blocks with a generic chain of STAGES stages, each carrying WIDTH bits of payload.
- Built-in handling: global busy-wait stall, depth-selectable flush, load-use bubble insertion and forwarding-source lookup.
- Placement: sits between decode and writeback. Upstream is the decode/issue logic; the datapath taps per-stage payloads for forwarding.

Parameters:
STAGES, 4, number of pipeline stages (2..8); stage 0 is youngest
WIDTH, 32, payload bits per stage
ADDR_W, 5, register-address width
SEL_W, 4, forwarding-select width; must satisfy 2^SEL_W > STAGES

Ports:
CLK  input  1  clock, rising edge
RESET  input  1  asynchronous, active-low reset
STALL  input  1  busy-wait (data or instruction cache); freezes the whole chain
FLUSH  input  1  flush request, sampled only on advancing edges
FLUSH_DEPTH  input  SEL_W  number of youngest stages killed by FLUSH (0..STAGES)
IN_VALID  input  1  issue slot holds an instruction
IN_DATA  input  WIDTH  issue payload
IN_RD  input  ADDR_W  destination register
IN_WE  input  1  instruction writes IN_RD
IN_IS_LOAD  input  1  instruction is a load
IN_RS1  input  ADDR_W  source register 1
IN_RS2  input  ADDR_W  source register 2
IN_READY  output  1  issue slot consumed this edge
STAGE_VALID  output  STAGES  per-stage valid bits
STAGE_DATA  output  STAGES*WIDTH  per-stage payloads; stage k occupies bits [k*WIDTH +: WIDTH]
OUT_VALID  output  1  equals STAGE_VALID[STAGES-1]
OUT_DATA  output  WIDTH  payload of the last stage
FWD1_SEL  output  SEL_W  0 = no forward; k+1 = forward from stage k
FWD2_SEL  output  SEL_W  same encoding for IN_RS2
LOAD_USE  output  1  load-use bubble inserted this cycle
STALL_CNT  output  32  performance counter (optional feature)
BUBBLE_CNT  output  32  performance counter (optional feature)
FLUSH_CNT  output  32  performance counter (optional feature)

Behaviour:
- Per-stage state: valid, data, rd, we, is_load.
- Reset (RESET=0, asynchronous, any time including mid-flush or mid-stall):
  - all state bits and data clear to 0 immediately;
  - all outputs read 0; counters clear to 0.
- Edge priority: RESET > STALL > FLUSH > load-use > normal advance.
- STALL=1:
  - every stage holds its contents; IN_READY=0; LOAD_USE=0;
  - FLUSH is ignored, so the requester must hold FLUSH until STALL deasserts.
- Normal advance:
  - stage k takes stage k-1 (k>=1); stage 0 takes the input;
  - stage 0 valid is set to IN_VALID; IN_READY=1;
  - OUT_* leaves the chain; no back-pressure from the last stage.
- Load-use hazard (combinational):
  - condition: stage0 valid, is_load, we, rd != 0, IN_VALID, and (IN_RS1 == rd or IN_RS2 == rd);
  - response: stages 1.. advance; stage 0 receives a bubble (valid=0, we=0, data=0); IN_READY=0; LOAD_USE=1.
- FLUSH=1 on an advancing edge with FLUSH_DEPTH=d:
  - after the shift, stages 0..d-1 become bubbles;
  - if d>=1 the input is discarded with IN_READY=1, and the load-use bubble is suppressed (LOAD_USE=0);
  - d=0: no kill;
  - d>STAGES: saturates to STAGES.
- Forwarding (combinational, every cycle including stall):
  - FWD1_SEL = k+1 for the smallest k with stage k valid, we, rd != 0 and rd == IN_RS1; otherwise 0;
  - FWD2_SEL uses the same rule with IN_RS2;
  - register x0 never matches.
- Latency: an instruction accepted at edge n appears on OUT_* after edge n+STAGES-1, plus one edge per stall cycle.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined:
  - STALL_CNT +1 per edge with STALL=1;
  - BUBBLE_CNT +1 per edge with LOAD_USE=1;
  - FLUSH_CNT +1 per advancing edge with FLUSH=1 and FLUSH_DEPTH != 0;
  - all counters saturate at 32'hFFFFFFFF.
- Undefined: counter logic is absent and all three outputs are tied to 0.

Test Plan:
- Reset release, then issue 4 valid instructions with data 1,2,3,4 on consecutive edges (STAGES=4) -> OUT_DATA=1 with OUT_VALID=1 after edge 4, then 2,3,4 on the following edges.
- Load in stage 0 (rd=5, is_load=1); next instruction has IN_RS1=5 -> LOAD_USE=1, IN_READY=0, STAGE_VALID[0]=0 after the edge; the instruction is accepted on the next edge with FWD1_SEL=2.
- STALL=1 for 3 edges with FLUSH=1, FLUSH_DEPTH=2 -> STAGE_VALID and STAGE_DATA unchanged; after STALL drops (FLUSH held) -> STAGE_VALID[1:0]=0; FLUSH_CNT=1 and STALL_CNT=3 with PIPE_PERF_CNT_EN.
- Stage 1 (rd=7, we=1) and stage 3 (rd=7, we=1) both valid, IN_RS2=7 -> FWD2_SEL=2; set IN_RS2=0 with a stage rd=0 -> FWD2_SEL=0.
- Load-use condition and FLUSH_DEPTH=1 on the same edge -> LOAD_USE=0, IN_READY=1, stage 0 bubble, stages 1..3 shifted.
- Assert RESET=0 between clock edges while the chain is full -> STAGE_VALID=0, OUT_DATA=0 immediately; no change at the next CLK edge while RESET is held low.
